// File: rtl/ac97_pkg.sv
// Shared AC-link definitions: slot width, codec register indices, scheduler
// state encoding and slot-1/slot-2 pack/unpack helpers.
package ac97_pkg;

  localparam int unsigned AC97_SLOT_W = 20;

  // Codec register indices
  localparam logic [6:0] RegReset     = 7'h00;
  localparam logic [6:0] RegMasterVol = 7'h02;
  localparam logic [6:0] RegPcmVol    = 7'h18;
  localparam logic [6:0] RegPowerdown = 7'h26;
  localparam logic [6:0] RegVid0      = 7'h7C;
  localparam logic [6:0] RegVid1      = 7'h7E;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRsp
  } sched_state_e;

  // Slot 1 command address: {rd, addr, 12'b0}
  function automatic logic [AC97_SLOT_W-1:0] pack_slot1(logic rd, logic [6:0] addr);
    return {rd, addr, 12'h000};
  endfunction

  // Slot 2 command data: {wdata, 4'b0}
  function automatic logic [AC97_SLOT_W-1:0] pack_slot2(logic [15:0] wdata);
    return {wdata, 4'h0};
  endfunction

  // Register index carried in an input status-address slot
  function automatic logic [6:0] unpack_slot1_addr(logic [AC97_SLOT_W-1:0] slot);
    return slot[18:12];
  endfunction

  // Register data carried in an input status-data slot
  function automatic logic [15:0] unpack_slot2_data(logic [AC97_SLOT_W-1:0] slot);
    return slot[19:4];
  endfunction

endpackage

// File: rtl/ac97_cmd_sched_if.sv
// Requester-side bus of the command scheduler: per-requester request
// fields and grant/completion pulses, plus the shared response data.
interface ac97_cmd_sched_if #(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*7-1:0]  req_addr;
  logic [NREQ*16-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [15:0]        rsp_rdata;
  logic               rsp_timeout;

  // Requester side
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout
  );

endinterface

// File: rtl/ac97_rr_arbiter.sv
// Round-robin arbiter: searches from the index after the last accepted grant,
// produces a one-hot grant and its index; pointer moves only when advance_i.
module ac97_rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    advance_i,
  output logic                    valid_o,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] gnt_idx_o
);

  localparam int unsigned IdxW = $clog2(NREQ);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx;
  logic            found;
  int unsigned     cand;

  // Priority search starting at the pointer, wrapping at NREQ
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IdxW-1:0];
      end
    end
  end

  // One-hot grant and pointer advance past the winner
  always_comb begin
    gnt_o      = '0;
    gnt_o[idx] = found;
    valid_o    = found;
    gnt_idx_o  = idx;
    ptr_d      = ptr_q;
    if (advance_i && found) begin
      ptr_d = (32'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ac97_cmd_sched.sv
// AC-link codec register-access scheduler: arbitrates NREQ requesters onto
// output slots 1/2, one command per frame, and returns read status or timeout.
// All state and slot updates happen on strobe cycles only.
module ac97_cmd_sched
  import ac97_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned TIMEOUT_FRAMES = 4
) (
  input  logic                   ac97_bitclk,
  input  logic                   ac97_rst_b,
  input  logic                   ac97_strobe,
  ac97_cmd_sched_if.slave        bus,
  input  logic                   ac97_in_codec_ready,
  input  logic                   ac97_in_slot1_valid,
  input  logic [AC97_SLOT_W-1:0] ac97_in_slot1,
  input  logic [AC97_SLOT_W-1:0] ac97_in_slot2,
  output logic [AC97_SLOT_W-1:0] ac97_out_slot1,
  output logic                   ac97_out_slot1_valid,
  output logic [AC97_SLOT_W-1:0] ac97_out_slot2,
  output logic                   ac97_out_slot2_valid
);

  localparam int unsigned IdxW = $clog2(NREQ);

  sched_state_e           state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   write_q, write_d;
  logic [6:0]             addr_q, addr_d;
  logic [3:0]             miss_q, miss_d;
  logic [AC97_SLOT_W-1:0] slot1_q, slot1_d, slot2_q, slot2_d;
  logic                   slot1_valid_q, slot1_valid_d, slot2_valid_q, slot2_valid_d;
  logic [NREQ-1:0]        req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [15:0]            rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_timeout_q, rsp_timeout_d;

  logic                   arb_valid;
  logic [NREQ-1:0]        arb_gnt;
  logic [IdxW-1:0]        arb_idx;
  logic                   do_arb, grant_en;
  logic [NREQ-1:0]        owner_oh;
  logic                   new_write;
  logic [6:0]             new_addr;
  logic [15:0]            new_wdata;

  ac97_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk_i    (ac97_bitclk),
    .rst_ni   (ac97_rst_b),
    .req_i    (bus.req_valid),
    .advance_i(grant_en),
    .valid_o  (arb_valid),
    .gnt_o    (arb_gnt),
    .gnt_idx_o(arb_idx)
  );

  // Owner one-hot and the winning requester's command fields
  always_comb begin
    owner_oh        = '0;
    owner_oh[idx_q] = 1'b1;
    new_write       = bus.req_write[arb_idx];
    new_addr        = bus.req_addr[32'(arb_idx)*7 +: 7];
    new_wdata       = bus.req_wdata[32'(arb_idx)*16 +: 16];
  end

  // Next-state and output logic; grant in the same strobe overrides slot clears
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    write_d       = write_q;
    addr_d        = addr_q;
    miss_d        = miss_q;
    slot1_d       = slot1_q;
    slot2_d       = slot2_q;
    slot1_valid_d = slot1_valid_q;
    slot2_valid_d = slot2_valid_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = 1'b0;
    do_arb        = 1'b0;
    grant_en      = 1'b0;

    if (ac97_strobe) begin
      case (state_q)
        StIdle: do_arb = 1'b1;
        StIssue: begin
          slot1_d       = '0;
          slot2_d       = '0;
          slot1_valid_d = 1'b0;
          slot2_valid_d = 1'b0;
          if (write_q) begin
            rsp_valid_d = owner_oh;
            rsp_rdata_d = '0;
            state_d     = StIdle;
            do_arb      = 1'b1;
          end else begin
            miss_d  = '0;
            state_d = StWaitRsp;
          end
        end
        StWaitRsp: begin
          if (ac97_in_slot1_valid && unpack_slot1_addr(ac97_in_slot1) == addr_q) begin
            rsp_valid_d = owner_oh;
            rsp_rdata_d = unpack_slot2_data(ac97_in_slot2);
            state_d     = StIdle;
          end else begin
            miss_d = miss_q + 4'd1;
            if (miss_d == 4'(TIMEOUT_FRAMES)) begin
              rsp_valid_d   = owner_oh;
              rsp_timeout_d = 1'b1;
              rsp_rdata_d   = '0;
              state_d       = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (do_arb && ac97_in_codec_ready && arb_valid) begin
        grant_en      = 1'b1;
        idx_d         = arb_idx;
        write_d       = new_write;
        addr_d        = new_addr;
        req_ready_d   = arb_gnt;
        slot1_d       = pack_slot1(!new_write, new_addr);
        slot1_valid_d = 1'b1;
        slot2_d       = new_write ? pack_slot2(new_wdata) : '0;
        slot2_valid_d = new_write;
        state_d       = StIssue;
      end
    end
  end

  // State and registered outputs; reset drops any command in flight
  always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
    if (!ac97_rst_b) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      miss_q        <= '0;
      slot1_q       <= '0;
      slot2_q       <= '0;
      slot1_valid_q <= 1'b0;
      slot2_valid_q <= 1'b0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      miss_q        <= miss_d;
      slot1_q       <= slot1_d;
      slot2_q       <= slot2_d;
      slot1_valid_q <= slot1_valid_d;
      slot2_valid_q <= slot2_valid_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready            = req_ready_q;
  assign bus.rsp_valid            = rsp_valid_q;
  assign bus.rsp_rdata            = rsp_rdata_q;
  assign bus.rsp_timeout          = rsp_timeout_q;
  assign ac97_out_slot1           = slot1_q;
  assign ac97_out_slot1_valid     = slot1_valid_q;
  assign ac97_out_slot2           = slot2_q;
  assign ac97_out_slot2_valid     = slot2_valid_q;

endmodule

// File: tb/tb_ac97_cmd_sched.sv
// Directed bench for ac97_cmd_sched with hand-computed expected values.
module tb_ac97_cmd_sched;

  logic        clk;
  logic        rst_b;
  logic        strobe;
  logic        codec_ready;
  logic        in_s1v;
  logic [19:0] in_s1;
  logic [19:0] in_s2;
  logic [19:0] out_s1;
  logic        out_s1v;
  logic [19:0] out_s2;
  logic        out_s2v;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned frame_pos;

  ac97_cmd_sched_if #(.NREQ(4)) bus ();

  ac97_cmd_sched #(
    .NREQ          (4),
    .TIMEOUT_FRAMES(4)
  ) dut (
    .ac97_bitclk         (clk),
    .ac97_rst_b          (rst_b),
    .ac97_strobe         (strobe),
    .bus                 (bus),
    .ac97_in_codec_ready (codec_ready),
    .ac97_in_slot1_valid (in_s1v),
    .ac97_in_slot1       (in_s1),
    .ac97_in_slot2       (in_s2),
    .ac97_out_slot1      (out_s1),
    .ac97_out_slot1_valid(out_s1v),
    .ac97_out_slot2      (out_s2),
    .ac97_out_slot2_valid(out_s2v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame strobe: one cycle in every 256, changed on the falling edge
  initial begin
    strobe    = 1'b0;
    frame_pos = 0;
    forever begin
      @(negedge clk);
      frame_pos = (frame_pos == 255) ? 0 : frame_pos + 1;
      strobe    = (frame_pos == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next strobe edge, then settle 1 time unit past it
  task automatic wait_strobe();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!strobe && n < 400);
    check("strobe_wait", {31'b0, strobe}, 32'd1);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [6:0] a,
                         input logic [15:0] d);
    bus.req_valid[i]         = v;
    bus.req_write[i]         = w;
    bus.req_addr[i*7 +: 7]   = a;
    bus.req_wdata[i*16 +: 16] = d;
  endtask

  initial begin
    int n;
    int bad;
    bit seen;
    int exp_ptr;
    int g;
    logic [31:0] prev_oh;
    logic [31:0] exp_oh;

    rst_b         = 1'b0;
    codec_ready   = 1'b0;
    in_s1v        = 1'b0;
    in_s1         = '0;
    in_s2         = '0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.req_ready, 0);
    check("rst_rsp", bus.rsp_valid, 0);
    check("rst_s1v", out_s1v, 0);
    check("rst_s2v", out_s2v, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_tmo", bus.rsp_timeout, 0);
    @(negedge clk);
    rst_b = 1'b1;

    // Codec not ready: request waits
    set_req(0, 1'b1, 1'b1, 7'h02, 16'h0000);
    for (int f = 0; f < 3; f++) begin
      wait_strobe();
      check("nordy_ready", bus.req_ready, 0);
      check("nordy_s1v", out_s1v, 0);
    end
    codec_ready = 1'b1;
    wait_strobe();
    check("wr_gnt", bus.req_ready, 32'h1);
    check("wr_s1", out_s1, 32'h02000);
    check("wr_s1v", out_s1v, 1);
    check("wr_s2", out_s2, 32'h00000);
    check("wr_s2v", out_s2v, 1);
    set_req(0, 1'b0, 1'b1, 7'h02, 16'h0000);
    @(posedge clk);
    #1;
    check("wr_gnt_pulse", bus.req_ready, 0);
    n    = 1;
    bad  = 0;
    seen = 0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.rsp_valid != 0) seen = 1;
      else if (!out_s1v) bad++;
    end
    check("wr_latency", n, 256);
    check("wr_rsp", bus.rsp_valid, 32'h1);
    check("wr_rdata", bus.rsp_rdata, 0);
    check("wr_tmo", bus.rsp_timeout, 0);
    check("wr_slot_hold", bad, 0);
    check("wr_s1v_clr", out_s1v, 0);
    @(posedge clk);
    #1;
    check("wr_rsp_pulse", bus.rsp_valid, 0);
    exp_ptr = 1;

    // All four requesters writing continuously: one grant per frame, in rotation
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 7'(16 + i), 16'(32'hA000 + i));
    prev_oh = 0;
    for (int k = 0; k < 6; k++) begin
      wait_strobe();
      g      = exp_ptr;
      exp_oh = 32'h1 << g;
      check("rr_gnt", bus.req_ready, exp_oh);
      check("rr_rsp", bus.rsp_valid, prev_oh);
      check("rr_s1", out_s1, 32'(16 + g) << 12);
      check("rr_s2", out_s2, 32'(32'hA000 + g) << 4);
      prev_oh = exp_oh;
      exp_ptr = (g + 1) % 4;
    end
    bus.req_valid = '0;
    wait_strobe();
    check("rr_last_rsp", bus.rsp_valid, prev_oh);
    check("rr_no_gnt", bus.req_ready, 0);
    check("rr_s1v_clr", out_s1v, 0);

    // Read with only unmatched status: timeout on the 4th wait frame
    set_req(3, 1'b1, 1'b0, 7'h26, 16'h0000);
    in_s1v = 1'b1;
    in_s1  = 20'h7C000;
    in_s2  = 20'h12340;
    wait_strobe();
    check("to_gnt", bus.req_ready, 32'h8);
    check("to_s1", out_s1, 32'hA6000);
    check("to_s2v", out_s2v, 0);
    set_req(3, 1'b0, 1'b0, 7'h26, 16'h0000);
    wait_strobe();
    check("to_issue_rsp", bus.rsp_valid, 0);
    for (int w = 1; w <= 4; w++) begin
      wait_strobe();
      if (w < 4) begin
        check("to_wait_rsp", bus.rsp_valid, 0);
      end else begin
        check("to_rsp", bus.rsp_valid, 32'h8);
        check("to_tmo", bus.rsp_timeout, 1);
        check("to_rdata", bus.rsp_rdata, 0);
      end
    end
    @(posedge clk);
    #1;
    check("to_tmo_pulse", bus.rsp_timeout, 0);
    in_s1v = 1'b0;

    // Read with matching status one frame after transmission
    set_req(1, 1'b1, 1'b0, 7'h7C, 16'h0000);
    wait_strobe();
    check("rd_gnt", bus.req_ready, 32'h2);
    check("rd_s1", out_s1, 32'hFC000);
    check("rd_s2v", out_s2v, 0);
    set_req(1, 1'b0, 1'b0, 7'h7C, 16'h0000);
    wait_strobe();
    check("rd_issue_rsp", bus.rsp_valid, 0);
    check("rd_issue_s1v", out_s1v, 0);
    in_s1v = 1'b1;
    in_s1  = 20'h7C000;
    in_s2  = 20'h41440;
    wait_strobe();
    check("rd_rsp", bus.rsp_valid, 32'h2);
    check("rd_rdata", bus.rsp_rdata, 32'h4144);
    check("rd_tmo", bus.rsp_timeout, 0);
    in_s1v = 1'b0;
    @(posedge clk);
    #1;
    check("rd_rsp_pulse", bus.rsp_valid, 0);
    check("rd_rdata_hold", bus.rsp_rdata, 32'h4144);

    // Reset while waiting for a read status
    set_req(2, 1'b1, 1'b0, 7'h26, 16'h0000);
    wait_strobe();
    check("rs_gnt", bus.req_ready, 32'h4);
    set_req(2, 1'b0, 1'b0, 7'h26, 16'h0000);
    wait_strobe();
    wait_strobe();
    check("rs_wait_rsp", bus.rsp_valid, 0);
    repeat (50) @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    check("rs_rdata", bus.rsp_rdata, 0);
    check("rs_ready", bus.req_ready, 0);
    check("rs_rsp", bus.rsp_valid, 0);
    check("rs_s1v", out_s1v, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    set_req(2, 1'b1, 1'b1, 7'h18, 16'h1234);
    set_req(3, 1'b1, 1'b1, 7'h02, 16'h5678);
    wait_strobe();
    check("rs_first_gnt", bus.req_ready, 32'h4);
    check("rs_no_old_rsp", bus.rsp_valid, 0);
    check("rs_s1", out_s1, 32'h18000);
    check("rs_s2", out_s2, 32'h12340);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ac97_cmd_sched.md
# ac97_cmd_sched

Codec register-access scheduler for the AC-link. Shares the single command channel (output slots 1/2) among NREQ requesters with round-robin arbitration, issues at most one command per 256-bit frame on `ac97_strobe`, and returns read status data (input slots 1/2) or a timeout to the owning requester. It replaces the fixed-sequence configuration FSM and connects directly to the link's slot-1/2 outputs and latched input frame.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT_FRAMES`, 4: frames to wait for a read status before giving up, 1..15.

- `ac97_bitclk` in 1: AC-link bit clock; the only clock.
- `ac97_rst_b` in 1: reset, asynchronous, active-low.
- `ac97_strobe` in 1: one-cycle pulse per frame, at bit 0; latched input frame is valid in this cycle.
- `req_valid` in NREQ: request pending per requester; held with its fields until `req_ready`.
- `req_write` in NREQ: 1 = write, 0 = read.
- `req_addr` in NREQ*7: register index, requester i at [7i+6:7i].
- `req_wdata` in NREQ*16: write data, requester i at [16i+15:16i].
- `req_ready` out NREQ: one-cycle grant pulse; request accepted.
- `rsp_valid` out NREQ: one-cycle completion pulse to the owner.
- `rsp_rdata` out 16: read data, valid with `rsp_valid`; 0 for writes and timeouts.
- `rsp_timeout` out 1: valid with `rsp_valid`; read got no matching status.
- `ac97_in_codec_ready` in 1: input tag bit 15.
- `ac97_in_slot1_valid` in 1: input tag bit 14.
- `ac97_in_slot1` in 20: status address; [18:12] = register index.
- `ac97_in_slot2` in 20: status data in [19:4].
- `ac97_out_slot1` out 20: {rd, addr[6:0], 12'b0}.
- `ac97_out_slot1_valid` out 1.
- `ac97_out_slot2` out 20: {wdata, 4'b0}.
- `ac97_out_slot2_valid` out 1.

## Operation
- States: IDLE, ISSUE, WAIT_RSP. All transitions and all slot-output updates happen only on cycles with `ac97_strobe`=1, so slot outputs are stable for a whole frame.
- IDLE, strobe, `ac97_in_codec_ready`=1, any `req_valid`: round-robin pick w, starting at the index after the last grant (pointer resets to 0). Latch w, write, addr, wdata. Pulse `req_ready[w]`. Load slot outputs:
  - slot1_valid=1.
  - slot2_valid=write.
  - slot2 = write ? {wdata,4'b0} : 0.
  - Next state ISSUE.
- If codec_ready=0, no grant; requests wait.
- ISSUE, next strobe: clear both slot valids and slot data to 0.
  - Write: pulse `rsp_valid[w]` with rdata=0, timeout=0. In the same strobe cycle, run IDLE arbitration (back-to-back writes, one per frame). A new grant in that cycle overrides the cleared slot values.
  - Read: clear the miss counter; go to WAIT_RSP.
- WAIT_RSP, each strobe:
  - If `ac97_in_slot1_valid`=1 and `ac97_in_slot1[18:12]`==addr: `rsp_rdata`=`ac97_in_slot2[19:4]`, pulse `rsp_valid[w]`, go IDLE. No arbitration in this cycle.
  - Else increment the miss counter. When it reaches TIMEOUT_FRAMES: pulse `rsp_valid[w]` with `rsp_timeout`=1, rdata=0, go IDLE.
  - Slot outputs stay invalid.
- Only one command is outstanding at a time. A requester that deasserts `req_valid` before its grant is ignored. `req_valid` in the grant cycle is the only sample taken.
- Unmatched status frames (wrong address) count as misses.

## Timing
- Reset (async assert, sync deassert on `ac97_bitclk`) sets:
  - state IDLE; all outputs 0;
  - RR pointer 0; miss counter 0.
- Reset mid-command drops the command; no response is issued.
- Grant to slot outputs: the same edge. Command is transmitted in the frame following the grant strobe.
- Write latency: grant strobe to `rsp_valid` is exactly 256 bitclks.
- Read latency: 512 bitclks at best (status in the next frame). Worst case is (TIMEOUT_FRAMES+1)*256 bitclks to timeout.
- `req_ready`, `rsp_valid`, `rsp_timeout` are high for exactly one cycle.
- `rsp_rdata` holds until the next response.

## Structure
- Shared package `ac97_pkg`:
  - `AC97_SLOT_W`=20;
  - register index constants: RESET 7'h00, MASTER_VOL 7'h02, PCM_VOL 7'h18, POWERDOWN 7'h26, VID0 7'h7C, VID1 7'h7E;
  - state enum;
  - slot-1/slot-2 pack/unpack functions.
- One sub-module: `ac97_rr_arbiter` (NREQ-wide request vector, advance-on-grant pointer, one-hot grant).

## Test plan
- Codec_ready=0 for 3 frames with req0 pending: no `req_ready`, slots invalid. Ready=1: grant at the next strobe.
- req0 write 0x02=0x0000: slot1=0x02000, slot2=0x00000, both valid for one frame. `rsp_valid[0]` 256 cycles after the grant.
- req1 read 0x7C, codec returns {0,0x7C,0} with slot2=0x41440 one frame later: `rsp_valid[1]`, `rsp_rdata`=0x4144, timeout=0.
- Read 0x26 with no matching status, TIMEOUT_FRAMES=4: `rsp_valid` with `rsp_timeout`=1 at the 4th WAIT_RSP strobe.
- All 4 requesting writes continuously: grants 0,1,2,3,0 on consecutive frames.
- Assert reset during WAIT_RSP: all outputs 0 immediately. After release, the pending req2 is granted first (pointer=0, req0/1 idle).
